// File: rtl/mul_step_seq_if.sv
// mul_step_seq_if
//   Bundles the control and status signals between the EBOX sequencer
//   (mul_step_seq) and whatever drives it.
//   master : drives start/count/hold/abort/mq35; observes the sequencer outputs
//   slave  : the sequencer itself
//   Signals:
//     start, count[5:0], hold, abort, mq35      -> sequencer
//     busy, done, mq_sel[1:0], ad_op[1:0],
//     ar_load, steps_left[5:0]                  <- sequencer
interface mul_step_seq_if;
  logic       start;
  logic [5:0] count;
  logic       hold;
  logic       abort;
  logic       mq35;
  logic       busy;
  logic       done;
  logic [1:0] mq_sel;
  logic [1:0] ad_op;
  logic       ar_load;
  logic [5:0] steps_left;

  modport master (
    output start, count, hold, abort, mq35,
    input  busy, done, mq_sel, ad_op, ar_load, steps_left
  );

  modport slave (
    input  start, count, hold, abort, mq35,
    output busy, done, mq_sel, ad_op, ar_load, steps_left
  );
endinterface

// File: rtl/mul_step_seq.sv
// mul_step_seq
//   Booth multiply step sequencer for the EBOX data path. After a start it
//   issues one Booth step per cycle (adder op, AR load, MQ shift) for the
//   requested number of steps, then pulses done for one cycle.
//   Ports:
//     clk        : data-path clock, rising edge
//     rst_n      : asynchronous active-low reset
//     bus        : mul_step_seq_if.slave (start/count/hold/abort/mq35 in;
//                  busy/done/mq_sel/ad_op/ar_load/steps_left out)
//     arith_cnt  : 16-bit saturating count of arithmetic STEP cycles
//                  (present only when MUL_SEQ_PERF_EN is defined)
//   Parameter:
//     MAX_STEPS  : largest legal step count; larger requests saturate
//   Optional feature macro: MUL_SEQ_PERF_EN
module mul_step_seq #(
  parameter int MAX_STEPS = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_step_seq_if.slave bus
`ifdef MUL_SEQ_PERF_EN
  ,
  output logic [15:0]   arith_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] MAX_CNT = 6'(MAX_STEPS);

  localparam logic [1:0] MQ_LOAD  = 2'b00;
  localparam logic [1:0] MQ_SHIFT = 2'b01;
  localparam logic [1:0] MQ_HOLD  = 2'b11;

  localparam logic [1:0] AD_PASS = 2'b00;
  localparam logic [1:0] AD_ADD  = 2'b01;
  localparam logic [1:0] AD_SUB  = 2'b10;

  state_t     state, state_nxt;
  logic       prev, prev_nxt;
  logic [5:0] steps_q, steps_nxt;
  logic [5:0] start_cnt;

  logic       busy_c;
  logic       done_c;
  logic [1:0] mq_sel_c;
  logic [1:0] ad_op_c;
  logic       ar_load_c;
  logic       start_ok;

  // Requests wider than the hardware supports are clamped, not wrapped.
  assign start_cnt = (bus.count > MAX_CNT) ? MAX_CNT : bus.count;

  // A start only counts when the sequencer is idle and nothing overrides it.
  assign start_ok = (state == IDLE) && bus.start && !bus.hold && !bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prev    <= 1'b0;
      steps_q <= 6'd0;
    end else begin
      state   <= state_nxt;
      prev    <= prev_nxt;
      steps_q <= steps_nxt;
    end
  end

  // Abort wins over everything, then hold freezes the machine and keeps the
  // data path quiet; a DONE under hold simply waits, so its pulse is deferred.
  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    steps_nxt = steps_q;
    busy_c    = (state != IDLE);
    done_c    = 1'b0;
    mq_sel_c  = MQ_HOLD;
    ad_op_c   = AD_PASS;
    ar_load_c = 1'b0;

    if (bus.abort) begin
      state_nxt = IDLE;
      prev_nxt  = 1'b0;
      steps_nxt = 6'd0;
    end else if (!bus.hold) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            steps_nxt = start_cnt;
            prev_nxt  = 1'b0;
            state_nxt = (start_cnt == 6'd0) ? DONE : STEP;
          end
        end
        STEP: begin
          mq_sel_c = MQ_SHIFT;
          // Booth radix-2 recode of the current multiplier bit and the one
          // shifted out last cycle.
          case ({bus.mq35, prev})
            2'b10:   ad_op_c = AD_SUB;
            2'b01:   ad_op_c = AD_ADD;
            default: ad_op_c = AD_PASS;
          endcase
          ar_load_c = (ad_op_c != AD_PASS);
          prev_nxt  = bus.mq35;
          if (steps_q != 6'd0) begin
            steps_nxt = steps_q - 6'd1;
          end
          if (steps_q <= 6'd1) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          prev_nxt  = 1'b0;
          steps_nxt = 6'd0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.mq_sel     = mq_sel_c;
  assign bus.ad_op      = ad_op_c;
  assign bus.ar_load    = ar_load_c;
  assign bus.steps_left = steps_q;

`ifdef MUL_SEQ_PERF_EN
  // ar_load is only ever high on a live STEP cycle, so it alone marks an
  // arithmetic step; the count sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arith_cnt <= 16'd0;
    end else if (start_ok) begin
      arith_cnt <= 16'd0;
    end else if (ar_load_c && (arith_cnt != 16'hFFFF)) begin
      arith_cnt <= arith_cnt + 16'd1;
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  localparam logic [1:0] UNUSED_MQ_LOAD = MQ_LOAD;
`endif

endmodule

// File: doc/mul_step_seq.md
MUL_STEP_SEQ -- requirements
Module: mul_step_seq

Interface
REQ-001 Parameter MAX_STEPS, default 36: largest legal step count; wider requests saturate to it.
REQ-002 clk  in  1  EBOX data-path clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  begin a multiply sequence; honoured only in IDLE.
REQ-005 count  in  6  number of Booth steps requested, sampled with start.
REQ-006 hold  in  1  stall; freezes all state and forces quiet outputs.
REQ-007 abort  in  1  cancel the sequence in progress.
REQ-008 mq35  in  1  current EDP.MQ[35], the multiplier LSB.
REQ-009 busy  out  1  high in STEP and DONE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 mq_sel  out  2  MQ register select: 00 load, 01 shift right, 11 hold (10 never driven).
REQ-012 ad_op  out  2  adder operation: 00 pass, 01 add BR, 10 subtract BR.
REQ-013 ar_load  out  1  load AR from AD this cycle.
REQ-014 steps_left  out  6  remaining step count.

Function
REQ-015 States: IDLE, STEP, DONE; no other states reachable.
REQ-016 IDLE + start: latch min(count, MAX_STEPS) into steps_left, clear prev to 0, go to STEP; if the latched value is 0, go to DONE instead.
REQ-017 STEP, hold=0: Booth decode of {mq35, prev}: 10 -> ad_op=10; 01 -> ad_op=01; 00/11 -> ad_op=00.
REQ-018 STEP, hold=0: ar_load=1 exactly when ad_op is nonzero; mq_sel=01.
REQ-019 STEP, hold=0, each cycle: prev <= mq35; steps_left <= steps_left-1.
REQ-020 STEP, hold=0, steps_left==1: go to DONE after that cycle.
REQ-021 DONE: done=1 for exactly one cycle; go to IDLE next cycle; steps_left reads 0.
REQ-022 Latency: start to done pulse is N+1 cycles for N steps, excluding hold cycles.
REQ-023 hold=1 in any state: ad_op=00, ar_load=0, mq_sel=11; state, prev and steps_left unchanged; a DONE pulse is deferred, not lost.
REQ-024 abort=1 has priority over hold and start: next state IDLE, steps_left<=0, prev<=0, no done pulse.
REQ-025 abort in the same cycle as start in IDLE: stays in IDLE.
REQ-026 start while busy: ignored, no effect on the sequence in progress.
REQ-027 Outputs in IDLE: ad_op=00, ar_load=0, mq_sel=11, done=0, busy=0.
REQ-028 steps_left never wraps; decrement occurs only in STEP with value >=1.

Reset
REQ-029 rst_n low: asynchronously force IDLE, prev=0, steps_left=0, busy=0, done=0, ad_op=00, ar_load=0, mq_sel=11.
REQ-030 rst_n low mid-sequence: the sequence is discarded; no done pulse after release.
REQ-031 First start is honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro MUL_SEQ_PERF_EN defined: add output arith_cnt (16 bits), a saturating count of STEP cycles with ar_load=1.
REQ-033 arith_cnt is cleared by reset and by an accepted start, holds at 16'hFFFF, and is readable at any time.
REQ-034 Macro MUL_SEQ_PERF_EN undefined: arith_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-035 start, count=4, mq35 sequence 1,0,1,1 -> ad_op 10,01,10,00; ar_load 1,1,1,0; done on cycle 5; busy cycles 1-5.
REQ-036 start, count=0 -> DONE next cycle with done=1; no STEP cycle; mq_sel held at 11 throughout.
REQ-037 count=3, hold high for 2 cycles after the first step -> outputs quiet during hold; steps_left holds at 2; done arrives 2 cycles late.
REQ-038 count=36, abort asserted at step 10 -> IDLE next cycle, steps_left=0, no done pulse; a new start is accepted the following cycle.
REQ-039 count=63 with MAX_STEPS=36 -> exactly 36 STEP cycles, then done.
REQ-040 MUL_SEQ_PERF_EN defined, count=8, mq35 alternating 1,0 -> arith_cnt=8; a new start clears it to 0.
